// File: rtl/bcd_serial_adder.sv
// -----------------------------------------------------------------------------
// bcd_serial_adder
//   Digit-serial packed-BCD adder. Two N_DIGITS-digit operands and a carry-in
//   are accepted over a valid/ready handshake. The block then adds one decimal
//   digit per clock, least significant digit first, applying the +6 decimal
//   correction. The result is offered over a second valid/ready handshake.
//
//   Digits above 9 are not rejected. They go through the same add/correct rule
//   so the result is always deterministic, and err reports that they were seen.
//
// Parameters
//   N_DIGITS   number of BCD digits per operand (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand transfer request
//   in_ready   block can accept operands (depends on state only)
//   a, b       packed BCD operands, digit 0 in bits [3:0]
//   cin        decimal carry into digit 0
//   out_valid  result available
//   out_ready  consumer accepts result
//   sum        packed BCD sum
//   cout       decimal carry out of the most significant digit
//   err        some input digit of a or b was greater than 9
// -----------------------------------------------------------------------------
module bcd_serial_adder #(
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*N_DIGITS-1:0] a,
  input  logic [4*N_DIGITS-1:0] b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*N_DIGITS-1:0] sum,
  output logic                  cout,
  output logic                  err
);

  localparam int W     = 4 * N_DIGITS;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [W-1:0]     a_q, b_q;
  logic [W-1:0]     sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             err_q;
  logic [IDX_W-1:0] idx_q;

  logic             accept;
  logic             last_digit;
  logic [3:0]       a_dig, b_dig;
  logic [4:0]       raw_sum;
  logic [4:0]       corr_sum;
  logic             dig_carry;
  logic [3:0]       dig_out;
  logic             dig_bad;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign last_digit = (idx_q == LAST_IDX);

  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: assigning a default first means no path leaves state_next unassigned,
  // so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)     state_next = ADD;
      ADD:     if (last_digit) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Current-digit adder with decimal correction
  // ---------------------------------------------------------------------------
  // The digit is picked with constant slices under an index compare, which
  // keeps every select in range for any N_DIGITS.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
  end

  // The widest raw sum is 15 + 15 + 1 = 31, so five bits never overflow.
  assign raw_sum   = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_q};
  assign corr_sum  = raw_sum + 5'd6;
  assign dig_carry = (raw_sum > 5'd9);
  assign dig_out   = dig_carry ? corr_sum[3:0] : raw_sum[3:0];
  assign dig_bad   = (a_dig > 4'd9) || (b_dig > 4'd9);

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // Operands are captured only on the accept edge, so a, b and cin may change
  // freely while an operation is in flight. The sum is cleared on accept so a
  // partial result never carries digits over from the previous operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        ADD: begin
          for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) sum_q[4*i +: 4] <= dig_out;
          end
          carry_q <= dig_carry;
          err_q   <= err_q | dig_bad;
          if (last_digit) begin
            cout_q <= dig_carry;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: ;  // DONE: the result is held until the consumer takes it
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_bcd_serial_adder
//   Self-checking bench for bcd_serial_adder. It uses a 4-digit instance for
//   the main scenarios and a 1-digit instance for the single-digit case.
//   Expected results come from a decimal reference model. For operands with
//   all digits valid, that model uses whole-number arithmetic; otherwise it
//   applies the digit-by-digit correction rule.
// -----------------------------------------------------------------------------
module tb_bcd_serial_adder;

  localparam int LAT_LIMIT = 20;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-digit instance
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, err;
  logic [15:0] a, b, sum;

  // 1-digit instance
  logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, err1;
  logic [3:0]  a1, b1, sum1;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_serial_adder #(.N_DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .err(err)
  );

  bcd_serial_adder #(.N_DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .err(err1)
  );

  // Reference model: returns {cout, err, sum}.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c);
    bit          valid = 1'b1;
    int          dx = 0, dy = 0, t, carry, d;
    logic [15:0] s = '0;
    for (int i = 0; i < 4; i++)
      if (x[4*i +: 4] > 9 || y[4*i +: 4] > 9) valid = 1'b0;
    if (valid) begin
      for (int i = 3; i >= 0; i--) begin
        dx = dx * 10 + int'(x[4*i +: 4]);
        dy = dy * 10 + int'(y[4*i +: 4]);
      end
      t = dx + dy + int'(c);
      for (int i = 0; i < 4; i++) begin
        s[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
      return {(dx + dy + int'(c)) >= 10000, 1'b0, s};
    end
    carry = int'(c);
    for (int i = 0; i < 4; i++) begin
      d = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + carry;
      if (d > 9) begin
        s[4*i +: 4] = 4'((d + 6) % 16);
        carry = 1;
      end else begin
        s[4*i +: 4] = 4'(d);
        carry = 0;
      end
    end
    return {carry != 0, 1'b1, s};
  endfunction

  // Drives one operation on the 4-digit instance. It is entered 1 ns after a
  // rising edge with the DUT idle and returns once out_valid is seen, or when
  // the cycle budget runs out. Inputs are scrambled right after the accept
  // edge so that any later sampling of them would show up.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic c,
                        output int lat, output bit ok);
    a = x; b = y; cin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < LAT_LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    ok = out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; a = '0; b = '0; cin = 0; out_ready = 1;
    in_valid1 = 0; a1 = '0; b1 = '0; cin1 = 0; out_ready1 = 1;
    #12;
    n_checks++;
    if ({in_ready, out_valid, cout, err, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset4: rdy=%b vld=%b cout=%b err=%b sum=%h, want 1 0 0 0 0000",
               in_ready, out_valid, cout, err, sum);
    end
    n_checks++;
    if ({in_ready1, out_valid1, sum1} !== {1'b1, 1'b0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset1: rdy=%b vld=%b sum=%h, want 1 0 0", in_ready1, out_valid1, sum1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [15:0] xs[5] = '{16'h1234, 16'h9999, 16'h9999, 16'h00A0, 16'h0000};
    logic [15:0] ys[5] = '{16'h5678, 16'h0001, 16'h9999, 16'h0000, 16'h0000};
    logic        cs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [17:0] want[5] = '{{2'b00, 16'h6912}, {2'b10, 16'h0000}, {2'b10, 16'h9999},
                             {2'b01, 16'h0100}, {2'b00, 16'h0001}};
    int lat; bit ok;
    for (int i = 0; i < 5; i++) begin
      run_op(xs[i], ys[i], cs[i], lat, ok);
      n_checks++;
      if (!ok || lat != 4) begin
        n_fail++;
        $display("FAIL dir_latency[%0d]: got %0d cycles (valid=%b), want 4", i, lat, ok);
      end
      n_checks++;
      if ({cout, err, sum} !== want[i]) begin
        n_fail++;
        $display("FAIL dir_result[%0d] %h+%h+%b: cout=%b err=%b sum=%h, want %b %b %h",
                 i, xs[i], ys[i], cs[i], cout, err, sum, want[i][17], want[i][16], want[i][15:0]);
      end
      n_checks++;
      if ({cout, err, sum} !== model(xs[i], ys[i], cs[i])) begin
        n_fail++;
        $display("FAIL dir_model[%0d]: got %h, model %h", i, {cout, err, sum},
                 model(xs[i], ys[i], cs[i]));
      end
      @(posedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL dir_return[%0d]: rdy=%b vld=%b, want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] held;
    int lat; bit ok;
    out_ready = 1'b0;
    run_op(16'h4821, 16'h3579, 1'b1, lat, ok);
    held = {cout, err, sum};
    n_checks++;
    if (!ok || held !== model(16'h4821, 16'h3579, 1'b1)) begin
      n_fail++;
      $display("FAIL bp_result: got %h (valid=%b), want %h", held, ok,
               model(16'h4821, 16'h3579, 1'b1));
    end
    in_valid = 1'b1;  // in_ready must not react to in_valid
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, err, sum} !== held) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: vld=%b rdy=%b res=%h, want 1 0 %h",
                 i, out_valid, in_ready, {cout, err, sum}, held);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_add();
    int lat; bit ok;
    a = 16'h9999; b = 16'h9999; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;   // accept
    in_valid = 1'b0;
    @(posedge clk); #1;   // digit 0 written, now in ADD cycle 2
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in_ready, cout, err, sum} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL rst_mid: vld=%b rdy=%b cout=%b err=%b sum=%h, want 0 1 0 0 0000",
               out_valid, in_ready, cout, err, sum);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h0005, 16'h0005, 1'b0, lat, ok);
    n_checks++;
    if (!ok || lat != 4 || {cout, err, sum} !== {2'b00, 16'h0010}) begin
      n_fail++;
      $display("FAIL rst_next_op: lat=%0d res=%h, want 4 %h", lat, {cout, err, sum},
               {2'b00, 16'h0010});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [15:0] x, y;
    logic        c;
    int lat; bit ok;
    for (int n = 0; n < 30; n++) begin
      if (n % 4 == 3) begin
        x = 16'($urandom); y = 16'($urandom);
      end else begin
        for (int i = 0; i < 4; i++) begin
          x[4*i +: 4] = 4'($urandom_range(0, 9));
          y[4*i +: 4] = 4'($urandom_range(0, 9));
        end
      end
      c = 1'($urandom);
      run_op(x, y, c, lat, ok);
      n_checks++;
      if (!ok || lat != 4 || {cout, err, sum} !== model(x, y, c)) begin
        n_fail++;
        $display("FAIL rand[%0d] %h+%h+%b: lat=%0d res=%h, want 4 %h",
                 n, x, y, c, lat, {cout, err, sum}, model(x, y, c));
      end
      @(posedge clk); #1;
    end
  endtask

  // in_valid is held high, so each op starts as soon as the block is ready
  // again; accepts must be exactly N_DIGITS+2 cycles apart.
  task automatic test_back_to_back();
    logic [17:0] exp_q[$];
    int          acc[$];
    int          got = 0;
    bit          was;
    a = 16'h2468; b = 16'h1357; cin = 1'b0; in_valid = 1'b1;
    for (int t = 0; t < 40 && got < 2; t++) begin
      was = in_ready && in_valid;
      if (was) exp_q.push_back(model(a, b, cin));
      @(posedge clk); #1;
      if (was) begin
        acc.push_back(t);
        a = 16'h0999; b = 16'h0001; cin = 1'b1;
        if (acc.size() == 2) in_valid = 1'b0;
      end
      if (out_valid) begin
        n_checks++;
        if (exp_q.size() == 0 || {cout, err, sum} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL b2b_result[%0d]: got %h, want %h", got, {cout, err, sum},
                   (exp_q.size() != 0) ? exp_q[0] : 18'h0);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (acc.size() != 2 || got != 2 || acc[1] - acc[0] != 6) begin
      n_fail++;
      $display("FAIL b2b_spacing: accepts=%0d results=%0d gap=%0d, want 2 2 6", acc.size(),
               got, (acc.size() == 2) ? acc[1] - acc[0] : -1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_n1();
    int lat;
    logic [3:0] x, y;
    logic       c;
    int         t;
    for (int n = 0; n < 8; n++) begin
      if (n == 0) begin
        x = 4'd7; y = 4'd8; c = 1'b1;
      end else begin
        x = 4'($urandom_range(0, 9)); y = 4'($urandom_range(0, 9)); c = 1'($urandom);
      end
      t = int'(x) + int'(y) + int'(c);
      a1 = x; b1 = y; cin1 = c; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < LAT_LIMIT) begin
        @(posedge clk); #1;
        lat++;
      end
      n_checks++;
      if (lat != 1 || sum1 !== 4'(t % 10) || cout1 !== (t >= 10) || err1 !== 1'b0) begin
        n_fail++;
        $display("FAIL n1[%0d] %0d+%0d+%b: lat=%0d sum=%h cout=%b err=%b, want 1 %0d %b 0",
                 n, x, y, c, lat, sum1, cout1, err1, t % 10, t >= 10);
      end
      @(posedge clk); #1;
      n_checks++;
      if (in_ready1 !== 1'b1) begin
        n_fail++;
        $display("FAIL n1_return[%0d]: rdy=%b, want 1", n, in_ready1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_add();
    test_random();
    test_back_to_back();
    test_n1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
